clkdiv_ratio_ctrl: RTL and testbench
====================================

Name: clkdiv_ratio_ctrl

Overview:
Upstream control stage for the clock divider. Accepts divide-ratio change requests over a valid/ready handshake and validates them. Sequences each change glitch-free: waits for the divided clock to be low, gates the divider enable, holds for a settle window, loads the new ratio, then re-enables. Drives the divider's enable and 32-bit ratio inputs, and monitors its divided-clock output as feedback.

Parameters:
DEFAULT_RATIO, 32'd2, ratio driven on o_div_ratio out of reset
MAX_RATIO, 32'd1024, largest accepted ratio; larger requests are rejected
SETTLE_CYCLES, 4, i_ref_clk cycles o_clk_en is held low before a new ratio loads (min 1)
TIMEOUT_CYCLES, 4096, wait-for-low limit (used only with the optional feature)

Ports:
i_ref_clk  input  1  reference clock; same clock as the divider
i_rst_n  input  1  reset, asynchronous, active-low
i_enable  input  1  global run request for the divider
i_req_valid  input  1  ratio change request valid
i_req_ratio  input  32  requested divide ratio
o_req_ready  output  1  request accepted when valid & ready
i_div_clk  input  1  divider output feedback (o_div_clk of the divider)
o_clk_en  output  1  divider enable (to i_clk_en)
o_div_ratio  output  32  divider ratio (to i_div_ratio)
o_busy  output  1  high while a change is in progress
o_err  output  1  one-cycle pulse when a request is rejected
o_timeout  output  1  one-cycle timeout pulse; tied 0 when the optional feature is off

Behaviour:
- Reset values: o_clk_en=0, o_div_ratio=DEFAULT_RATIO, o_busy=0, o_err=0, o_timeout=0, state=OFF, settle counter=0.
- i_div_clk is sampled by one flop (div_q) on posedge i_ref_clk. All decisions use div_q.
- States are OFF, RUN, WAIT_LOW, GATE and LOAD.
- OFF:
  - o_clk_en=0.
  - i_enable=1 -> RUN on the next cycle.
  - A valid request in OFF is accepted and loaded directly into o_div_ratio in the same accept cycle, with no gating.
- RUN:
  - o_clk_en=1 and o_req_ready=1.
  - i_enable=0 -> OFF. Enable drop has priority over a simultaneous request; the request is not accepted.
  - Accepted legal request -> latch the ratio into pend_ratio, then go to WAIT_LOW.
- Request validation happens at the accept cycle:
  - Legal: 0, 1, or 2..MAX_RATIO. Ratios 0 and 1 mean pass-through in the divider and are accepted.
  - Illegal (> MAX_RATIO): o_err=1 on the cycle after accept, state unchanged, o_div_ratio unchanged. The handshake still completes (ready=1).
- WAIT_LOW:
  - o_req_ready=0 and o_busy=1; o_clk_en stays 1.
  - div_q==0 -> GATE.
  - If pend_ratio equals o_div_ratio, go directly back to RUN (no-op change, no gating).
- GATE:
  - o_clk_en=0 and o_busy=1.
  - Counter counts SETTLE_CYCLES cycles, then -> LOAD.
- LOAD:
  - Lasts one cycle; o_div_ratio <= pend_ratio.
  - Next state is RUN if i_enable=1, otherwise OFF. o_clk_en rises on the RUN cycle.
- Latency: a legal change with div_q already low gives o_clk_en low 2 cycles after accept. New ratio visible at accept + 2 + SETTLE_CYCLES.
- i_enable dropping during WAIT_LOW or GATE: the change completes to LOAD, then goes to OFF. No request is lost.
- o_req_ready is 0 in WAIT_LOW, GATE and LOAD. Requests are held by the sender (valid stays high, data stable).
- Asynchronous reset mid-change aborts the change; pend_ratio is discarded and o_div_ratio returns to DEFAULT_RATIO.

Optional Feature:
CLKDIV_CTRL_TIMEOUT_EN
- Defined:
  - A 32-bit counter runs in WAIT_LOW.
  - On reaching TIMEOUT_CYCLES without div_q==0, pulse o_timeout for 1 cycle and force a transition to GATE.
  - Counter clears on WAIT_LOW entry.
- Undefined: no counter; o_timeout tied 0; WAIT_LOW waits indefinitely.

Decomposition:
- Shared package clkdiv_pkg:
  - state encoding constants OFF/RUN/WAIT_LOW/GATE/LOAD (3-bit)
  - RATIO_W=32
  - shared default-ratio constant (also usable by the divider)
- One natural sub-module: clkdiv_settle_cnt, a loadable down-counter with a done flag. It is used for the SETTLE window and reused for the timeout.

Test Plan:
- Reset, then i_enable=1 -> o_clk_en=1 one cycle later; o_div_ratio=2.
- In RUN, request ratio 6 with i_div_clk low -> o_clk_en=0 for 4 cycles, o_div_ratio=6 at accept+6, o_clk_en=1 next cycle; o_busy spans this window.
- Request ratio 2000 -> o_err pulses 1 cycle, o_div_ratio stays 2, o_clk_en never drops.
- Request ratio 5 while i_div_clk held high for 20 cycles -> o_clk_en stays 1 until 1 cycle after the first sampled low, then the normal gate/load sequence runs.
- Request ratio 3, then drop i_enable during GATE -> o_div_ratio=3 after LOAD, state OFF, o_clk_en=0; assert i_rst_n=0 mid-GATE on a rerun -> o_div_ratio=2 immediately.
- With CLKDIV_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, i_div_clk stuck high -> o_timeout pulses at WAIT_LOW entry+16, then the ratio loads after the settle window.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider control slice: ratio width,
// default ratio, FSM state encoding and the ratio legality rule.
package clkdiv_pkg;

  localparam int RATIO_W = 32;

  // Ratio used out of reset; also usable by the divider itself.
  localparam logic [RATIO_W-1:0] CLKDIV_DEFAULT_RATIO = 32'd2;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_GATE     = 3'd3,
    ST_LOAD     = 3'd4
  } clkdiv_state_e;

  // 0 and 1 mean pass-through in the divider, so only the upper bound matters.
  function automatic logic ratio_legal(input logic [RATIO_W-1:0] ratio,
                                       input logic [RATIO_W-1:0] max_ratio);
    return (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/clkdiv_ratio_ctrl_settle_cnt.sv
// Loadable down-counter with a zero flag. Holds at zero once it gets there.
// Used for the settle window and, when enabled, the wait-for-low timeout.
module clkdiv_settle_cnt #(
  parameter int W = 32
) (
  input  logic         i_ref_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down toward zero and stop there.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio-change controller for the clock divider. Accepts ratio requests on a
// valid/ready handshake, validates them, and sequences each change so the
// divider is only gated while its output is low: wait low, gate, settle,
// load, re-enable.
// Optional: define CLKDIV_CTRL_TIMEOUT_EN to bound the wait-for-low phase;
// on expiry o_timeout pulses and the change proceeds to the gate phase.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO  = CLKDIV_DEFAULT_RATIO,
  parameter logic [RATIO_W-1:0] MAX_RATIO      = 32'd1024,
  parameter int                 SETTLE_CYCLES  = 4,
  parameter int                 TIMEOUT_CYCLES = 4096
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  output logic               o_req_ready,
  input  logic               i_div_clk,
  output logic               o_clk_en,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_timeout
);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("clkdiv_ratio_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  clkdiv_state_e      r_state;
  logic               r_div_q;
  logic               r_clk_en;
  logic               r_busy;
  logic               r_err;
  logic               r_timeout;
  logic [RATIO_W-1:0] r_div_ratio;
  logic [RATIO_W-1:0] r_pend_ratio;

  logic w_settle_done;
  logic w_to_done;
  logic w_req_legal;

  assign w_req_legal = ratio_legal(i_req_ratio, MAX_RATIO);

  // Feedback synchroniser: every decision below looks at r_div_q only.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_div_q <= 1'b0;
    else          r_div_q <= i_div_clk;
  end

  // Settle counter reloads every WAIT_LOW cycle so it is primed on GATE entry;
  // loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles in GATE.
  clkdiv_settle_cnt #(.W(RATIO_W)) u_settle (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (r_state == ST_WAIT_LOW),
    .i_load_val (RATIO_W'(SETTLE_CYCLES - 1)),
    .i_dec      (r_state == ST_GATE),
    .o_done     (w_settle_done)
  );

`ifdef CLKDIV_CTRL_TIMEOUT_EN
  // Timeout counter is held loaded outside WAIT_LOW, so it restarts on entry
  // and expires on the TIMEOUT_CYCLES-th WAIT_LOW cycle.
  clkdiv_settle_cnt #(.W(32)) u_timeout (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (r_state != ST_WAIT_LOW),
    .i_load_val (32'(TIMEOUT_CYCLES - 1)),
    .i_dec      (r_state == ST_WAIT_LOW),
    .o_done     (w_to_done)
  );
`else
  assign w_to_done = 1'b0;
`endif

  // Main sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_OFF;
      r_clk_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
      r_div_ratio  <= DEFAULT_RATIO;
      r_pend_ratio <= DEFAULT_RATIO;
    end else begin
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_OFF: begin
          // Divider is stopped, so a legal ratio can be applied directly.
          if (i_req_valid) begin
            if (w_req_legal) r_div_ratio <= i_req_ratio;
            else             r_err       <= 1'b1;
          end
          if (i_enable) begin
            r_state  <= ST_RUN;
            r_clk_en <= 1'b1;
          end
        end
        ST_RUN: begin
          // Enable drop wins over a simultaneous request (ready is low then).
          if (!i_enable) begin
            r_state  <= ST_OFF;
            r_clk_en <= 1'b0;
          end else if (i_req_valid) begin
            if (w_req_legal) begin
              r_pend_ratio <= i_req_ratio;
              r_state      <= ST_WAIT_LOW;
              r_busy       <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WAIT_LOW: begin
          if (r_pend_ratio == r_div_ratio) begin
            // Same ratio: nothing to change, skip the gating entirely.
            r_busy   <= 1'b0;
            r_state  <= i_enable ? ST_RUN : ST_OFF;
            r_clk_en <= i_enable;
          end else if (!r_div_q) begin
            r_state  <= ST_GATE;
            r_clk_en <= 1'b0;
          end else if (w_to_done) begin
            r_timeout <= 1'b1;
            r_state   <= ST_GATE;
            r_clk_en  <= 1'b0;
          end
        end
        ST_GATE: begin
          // Ratio is updated on LOAD entry so it is visible during LOAD.
          if (w_settle_done) begin
            r_state     <= ST_LOAD;
            r_div_ratio <= r_pend_ratio;
          end
        end
        ST_LOAD: begin
          r_busy   <= 1'b0;
          r_state  <= i_enable ? ST_RUN : ST_OFF;
          r_clk_en <= i_enable;
        end
        default: begin
          r_state  <= ST_OFF;
          r_clk_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_OFF) || ((r_state == ST_RUN) && i_enable);
  assign o_clk_en    = r_clk_en;
  assign o_div_ratio = r_div_ratio;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
  assign o_timeout   = r_timeout;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Self-checking bench for clkdiv_ratio_ctrl: directed vector table from reset,
// randomized ratio changes against a timeline model, and hand-written
// sequences for enable drop, async reset mid-change and (if enabled) timeout.
module tb_clkdiv_ratio_ctrl;

  localparam logic [31:0] DEF    = 32'd2;
  localparam logic [31:0] MAXR   = 32'd1024;
  localparam int          SETTLE = 4;
  localparam int          TOUT   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vld;
  logic [31:0] req_ratio;
  logic        rdy;
  logic        div_clk;
  logic        clk_en;
  logic [31:0] div_ratio;
  logic        busy;
  logic        err;
  logic        tout;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur;

  clkdiv_ratio_ctrl #(
    .DEFAULT_RATIO  (DEF),
    .MAX_RATIO      (MAXR),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_enable    (en),
    .i_req_valid (vld),
    .i_req_ratio (req_ratio),
    .o_req_ready (rdy),
    .i_div_clk   (div_clk),
    .o_clk_en    (clk_en),
    .o_div_ratio (div_ratio),
    .o_busy      (busy),
    .o_err       (err),
    .o_timeout   (tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] ratio;
    logic        div;
    logic        e_clk;
    logic [31:0] e_ratio;
    logic        e_busy;
    logic        e_err;
    logic        e_ready;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic e_clk, input logic [31:0] e_ratio,
                         input logic e_busy, input logic e_err, input logic e_ready);
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(e_clk));
    chk({tag, ".ratio"},  div_ratio,   e_ratio);
    chk({tag, ".busy"},   32'(busy),   32'(e_busy));
    chk({tag, ".err"},    32'(err),    32'(e_err));
    chk({tag, ".ready"},  32'(rdy),    32'(e_ready));
    chk({tag, ".tout"},   32'(tout),   32'd0);
  endtask

  // Reference timeline of one request issued in RUN. The divider input is
  // high for the first h sampling edges after the request, low afterwards.
  // A real change gates at h+2, loads at h+2+SETTLE and runs again one later.
  task automatic run_txn(input logic [31:0] r, input int h);
    bit legal = (r <= MAXR);
    bit noop  = legal && (r == cur);
    int g     = h + 2;
    int ld    = h + 2 + SETTLE;
    int last  = (legal && !noop) ? ld + 2 : 3;
    logic e_clk, e_busy, e_err;
    logic [31:0] e_ratio;
    vld = 1'b1; req_ratio = r; div_clk = (h > 0);
    for (int t = 1; t <= last; t++) begin
      tick();
      vld = 1'b0;
      div_clk = (t < h);
      if (!legal) begin
        e_clk = 1'b1; e_busy = 1'b0; e_err = (t == 1); e_ratio = cur;
      end else if (noop) begin
        e_clk = 1'b1; e_busy = (t == 1); e_err = 1'b0; e_ratio = cur;
      end else begin
        e_clk = !(t >= g && t <= ld); e_busy = (t <= ld); e_err = 1'b0;
        e_ratio = (t >= ld) ? r : cur;
      end
      chk_all($sformatf("rnd r=%0d h=%0d t=%0d", r, h, t), e_clk, e_ratio, e_busy, e_err, !e_busy);
    end
    if (legal) cur = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int h, k;

    tbl[0]  = '{1'b0, 1'b1, 32'd7,    1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'd2000, 1'b0, 1'b0, 32'd7, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'd9,    1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'd9,    1'b0, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd0,    1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'd4,    1'b0, 1'b0, 32'd9, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd9, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'd0,    1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 32'd2,    1'b0, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0};
    for (int i = 10; i < 14; i++)
      tbl[i] = '{1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 32'd9, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'd0,    1'b0, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 32'd0,    1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; req_ratio = '0; div_clk = 1'b0;
    repeat (3) tick();
    chk_all("reset", 1'b0, DEF, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Directed vectors from OFF: direct loads, reject, enable, no-op, full change
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; vld = tbl[i].vld; req_ratio = tbl[i].ratio; div_clk = tbl[i].div;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_ratio, tbl[i].e_busy,
              tbl[i].e_err, tbl[i].e_ready);
    end
    vld = 1'b0;
    cur = 32'd2;

    // Randomized changes in RUN, including boundary ratios and no-ops
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: r = $urandom_range(0, 1024);
        3, 4:    r = cur;
        5, 6:    r = 32'd1025 + $urandom_range(0, 100000);
        7:       r = 32'd0;
        8:       r = MAXR;
        default: r = MAXR + 32'd1;
      endcase
      h = $urandom_range(0, 6);
      run_txn(r, h);
      tick();
      chk_all("idle", 1'b1, cur, 1'b0, 1'b0, 1'b1);
    end

    // Long wait-for-low: divider high for 20 samples, then the normal sequence
    if (cur == 32'd5) run_txn(32'd6, 0);
    run_txn(32'd5, 20);

    // Enable dropped mid-GATE: change still lands, then OFF
    if (cur == 32'd3) run_txn(32'd10, 0);
    vld = 1'b1; req_ratio = 32'd3; div_clk = 1'b0;
    tick(); vld = 1'b0;
    chk_all("drop t1", 1'b1, cur, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("drop t2", 1'b0, cur, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    repeat (4) tick();
    chk_all("drop load", 1'b0, 32'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("drop off", 1'b0, 32'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("drop off2", 1'b0, 32'd3, 1'b0, 1'b0, 1'b1);

    // Rerun, then async reset in GATE aborts the change
    en = 1'b1;
    tick();
    chk_all("rerun", 1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
    vld = 1'b1; req_ratio = 32'd5;
    tick(); vld = 1'b0;
    tick(); tick();
    chk_all("pre-rst gate", 1'b0, 32'd3, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0; en = 1'b0;
    #1 chk_all("async rst", 1'b0, DEF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("post rst", 1'b0, DEF, 1'b0, 1'b0, 1'b1);
    cur = DEF;

`ifdef CLKDIV_CTRL_TIMEOUT_EN
    // Divider stuck high: timeout at WAIT_LOW entry + TOUT, then settle and load
    en = 1'b1;
    tick();
    vld = 1'b1; req_ratio = 32'd8; div_clk = 1'b1;
    for (int t = 1; t <= TOUT + 1 + SETTLE + 1; t++) begin
      tick(); vld = 1'b0;
      if (t >= TOUT && t <= TOUT + 2)
        chk($sformatf("timeout t=%0d", t), 32'(tout), 32'(t == TOUT + 1));
      if (t == TOUT)      chk("to clk_en hi", 32'(clk_en), 32'd1);
      if (t == TOUT + 1)  chk("to clk_en lo", 32'(clk_en), 32'd0);
      if (t == TOUT + SETTLE)     chk("to ratio old", div_ratio, DEF);
      if (t == TOUT + 1 + SETTLE) chk("to ratio new", div_ratio, 32'd8);
    end
    div_clk = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
